// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light blocks: controller state encodings,
// phase indices, lamp bit positions and the round-robin phase selector.
package traffic_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_GREEN  = 3'd1;
   localparam logic [2:0] ST_YELLOW = 3'd2;
   localparam logic [2:0] ST_ALLRED = 3'd3;

   localparam logic [1:0] PH_WN_ES = 2'd0;
   localparam logic [1:0] PH_NE_SW = 2'd1;
   localparam logic [1:0] PH_EW    = 2'd2;
   localparam logic [1:0] PH_NS    = 2'd3;

   localparam int LAMP_WN_ES = 0;
   localparam int LAMP_NE_SW = 1;
   localparam int LAMP_EW    = 2;
   localparam int LAMP_NS    = 3;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } rr_sel_t;

   function automatic logic [3:0] phase_onehot(input logic [1:0] ph);
      return 4'b0001 << ph;
   endfunction

   // Descending scan so the smallest offset from last+1 wins; offset 4 is last itself.
   function automatic rr_sel_t rr_select(input logic [3:0] req, input logic [1:0] last);
      rr_sel_t    sel;
      logic [1:0] cand;
      sel.found = 1'b0;
      sel.idx   = last;
      for (int i = 4; i >= 1; i--) begin
         cand = last + 2'(i);
         if (req[cand]) begin
            sel.found = 1'b1;
            sel.idx   = cand;
         end else begin
            sel = sel;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/traffic_phase_scheduler_timer.sv
// Interval down counter: loads value-1 on entry, counts to zero and holds;
// done is high while the count reads zero.
module phase_timer #(
   parameter int WL = 8
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          load,
   input  logic [WL-1:0] load_val,
   output logic          done
);

   localparam logic [WL-1:0] ZERO_W = {WL{1'b0}};
   localparam logic [WL-1:0] ONE_W  = {{(WL-1){1'b0}}, 1'b1};

   logic [WL-1:0] count_r;

   // Load has priority over the decrement so an interval can restart at zero.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         count_r <= ZERO_W;
      end else if (load) begin
         count_r <= load_val;
      end else if (count_r != ZERO_W) begin
         count_r <= count_r - ONE_W;
      end else begin
         count_r <= count_r;
      end
   end

   assign done = (count_r == ZERO_W);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-phase round-robin signal controller with green extension on lone demand
// and an all-red clearance interval between every change of right-of-way.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int WL         = 8,
   parameter int GREEN_CYC  = 20,
   parameter int YELLOW_CYC = 4,
   parameter int ALLRED_CYC = 2,
   parameter int MAX_EXT    = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] Car,
   output logic [3:0] Green,
   output logic [3:0] Yellow,
   output logic [3:0] Red,
   output logic [1:0] Phase,
   output logic       Busy
);

   localparam logic [WL-1:0] GREEN_LD  = WL'(GREEN_CYC - 1);
   localparam logic [WL-1:0] YELLOW_LD = WL'(YELLOW_CYC - 1);
   localparam logic [WL-1:0] ALLRED_LD = WL'(ALLRED_CYC - 1);
   localparam logic [WL-1:0] MAX_EXT_W = WL'(MAX_EXT);
   localparam logic [WL-1:0] ZERO_W    = {WL{1'b0}};
   localparam logic [WL-1:0] ONE_W     = {{(WL-1){1'b0}}, 1'b1};

   logic [2:0]    state_r, state_nxt_s;
   logic [1:0]    phase_r, phase_nxt_s;
   logic [3:0]    pending_r, pending_nxt_s;
   logic [WL-1:0] ext_r, ext_nxt_s;
   logic [3:0]    green_r, yellow_r, red_r;
   logic          busy_r;

   logic [3:0]    demand_s, set_mask_s, others_s;
   rr_sel_t       sel_s;
   logic          ext_ok_s, enter_green_s, timer_done_s, load_s;
   logic [WL-1:0] load_val_s;

   assign demand_s   = pending_r | Car;
   assign sel_s      = rr_select(demand_s, phase_r);
   assign others_s   = demand_s & ~phase_onehot(phase_r);
   assign ext_ok_s   = Car[phase_r] && (others_s == 4'b0000) && (ext_r < MAX_EXT_W);
   // The served phase's own sensor does not latch while it is green.
   assign set_mask_s = (state_r == ST_GREEN) ? ~phase_onehot(phase_r) : 4'b1111;

   // Next-state, interval timer control and extension bookkeeping.
   always_comb begin
      state_nxt_s   = state_r;
      ext_nxt_s     = ext_r;
      enter_green_s = 1'b0;
      load_s        = 1'b0;
      load_val_s    = GREEN_LD;
      case (state_r)
         ST_IDLE: begin
            enter_green_s = sel_s.found;
         end
         ST_GREEN: begin
            if (timer_done_s && ext_ok_s) begin
               load_s    = 1'b1;
               ext_nxt_s = ext_r + ONE_W;
            end else if (timer_done_s) begin
               state_nxt_s = ST_YELLOW;
               load_s      = 1'b1;
               load_val_s  = YELLOW_LD;
            end else begin
               state_nxt_s = ST_GREEN;
            end
         end
         ST_YELLOW: begin
            if (timer_done_s) begin
               state_nxt_s = ST_ALLRED;
               load_s      = 1'b1;
               load_val_s  = ALLRED_LD;
            end else begin
               state_nxt_s = ST_YELLOW;
            end
         end
         ST_ALLRED: begin
            if (timer_done_s) begin
               enter_green_s = sel_s.found;
               state_nxt_s   = ST_IDLE;
            end else begin
               state_nxt_s = ST_ALLRED;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            ext_nxt_s   = ZERO_W;
         end
      endcase
      state_nxt_s   = enter_green_s ? ST_GREEN : state_nxt_s;
      ext_nxt_s     = enter_green_s ? ZERO_W : ext_nxt_s;
      load_s        = enter_green_s | load_s;
      load_val_s    = enter_green_s ? GREEN_LD : load_val_s;
      phase_nxt_s   = enter_green_s ? sel_s.idx : phase_r;
      pending_nxt_s = (pending_r | (Car & set_mask_s))
                    & ~(enter_green_s ? phase_onehot(sel_s.idx) : 4'b0000);
   end

   phase_timer #(.WL(WL)) u_timer (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .load     (load_s),
      .load_val (load_val_s),
      .done     (timer_done_s)
   );

   // State registers; lamps are registered from the next state so they track state_r exactly.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_r   <= ST_IDLE;
         phase_r   <= PH_NS;
         pending_r <= 4'b0000;
         ext_r     <= ZERO_W;
         green_r   <= 4'b0000;
         yellow_r  <= 4'b0000;
         red_r     <= 4'b1111;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         phase_r   <= phase_nxt_s;
         pending_r <= pending_nxt_s;
         ext_r     <= ext_nxt_s;
         green_r   <= (state_nxt_s == ST_GREEN)  ? phase_onehot(phase_nxt_s) : 4'b0000;
         yellow_r  <= (state_nxt_s == ST_YELLOW) ? phase_onehot(phase_nxt_s) : 4'b0000;
         red_r     <= ((state_nxt_s == ST_GREEN) || (state_nxt_s == ST_YELLOW))
                      ? ~phase_onehot(phase_nxt_s) : 4'b1111;
         busy_r    <= (state_nxt_s != ST_IDLE);
      end
   end

   assign Green  = green_r;
   assign Yellow = yellow_r;
   assign Red    = red_r;
   assign Phase  = phase_r;
   assign Busy   = busy_r;

endmodule
